// File: rtl/ctr_load_sched.sv
// ctr_load_sched: round-robin scheduler that shares one loadable wrap-at-WRAP
// counter between NREQ requesters. It sequences load/data_in, verifies the
// counter took the value, and flags every natural terminal-count wrap.
// Optional build macro: CTR_SCHED_PRIO_EN (requester 0 gets absolute priority).
module ctr_load_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int WRAP = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               err,
    output logic               load,
    output logic [DW-1:0]      data_in,
    input  logic [DW-1:0]      data_out,
    output logic               busy,
    output logic               wrap_pulse
);
    localparam int IW = $clog2(NREQ);
    localparam logic [DW-1:0] WRAP_V = DW'(WRAP);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   pick, cand;
    logic            any_req;
    logic [DW-1:0]   slot [NREQ];

    logic [NREQ-1:0] gnt_d;
    logic            err_d, load_d, busy_d, wrap_d;
    logic [DW-1:0]   data_in_d;

    // Arbitration: first requester at or after the pointer, wrapping around
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot[i] = req_data[i*DW +: DW];
            cand    = IW'((32'(ptr_q) + i) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
`ifdef CTR_SCHED_PRIO_EN
        if (req[0]) begin
            any_req = 1'b1;
            pick    = '0;
        end
`endif
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        data_d    = data_q;
        gnt_d     = '0;
        err_d     = 1'b0;
        load_d    = 1'b0;
        data_in_d = data_in;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d  = pick;
                    data_d = slot[pick];
                    if (slot[pick] <= WRAP_V) begin
                        state_d   = LOAD;
                        load_d    = 1'b1;
                        data_in_d = slot[pick];
                    end else begin
                        // Out-of-range value: complete immediately, counter untouched
                        state_d     = DONE;
                        gnt_d[pick] = 1'b1;
                        err_d       = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d      = DONE;
                gnt_d[win_q] = 1'b1;
                err_d        = (data_out != data_q);
            end
            DONE: begin
                state_d = IDLE;
`ifdef CTR_SCHED_PRIO_EN
                if (win_q != '0) begin
                    ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
                end
`else
                ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        // A coincident load overrides the wrap, so no pulse then
        wrap_d = (data_out == WRAP_V) && !load;
    end

    // State, latched transfer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            data_q     <= '0;
            gnt        <= '0;
            err        <= 1'b0;
            load       <= 1'b0;
            data_in    <= '0;
            busy       <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            data_q     <= data_d;
            gnt        <= gnt_d;
            err        <= err_d;
            load       <= load_d;
            data_in    <= data_in_d;
            busy       <= busy_d;
            wrap_pulse <= wrap_d;
        end
    end

endmodule

// File: tb/tb_ctr_load_sched.sv
// tb_ctr_load_sched: directed vectors for ctr_load_sched with a behavioural
// wrap-at-12 counter attached to load/data_in/data_out.
module tb_ctr_load_sched;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic        err;
    logic        load;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        busy;
    logic        wrap_pulse;

    logic [3:0]  cnt;
    logic        corrupt;

    int n_cmp;
    int n_bad;

    ctr_load_sched #(.NREQ(4), .DW(4), .WRAP(12)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .err(err), .load(load), .data_in(data_in),
        .data_out(data_out), .busy(busy), .wrap_pulse(wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter: load has priority, wraps 12 -> 0
    always_ff @(posedge clk) begin
        if (rst)             cnt <= '0;
        else if (load)       cnt <= data_in;
        else if (cnt == 4'd12) cnt <= '0;
        else                 cnt <= cnt + 4'd1;
    end
    assign data_out = corrupt ? (cnt ^ 4'h1) : cnt;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] rdata;
        bit          corrupt;
        logic [3:0]  exp_gnt;
        bit          exp_err;
        int          lat;
        logic [3:0]  exp_val;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req     = '0;
        corrupt = 1'b0;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (gnt == '0 && cyc < 12);
        chk("wait_gnt", {31'd0, |gnt}, 32'd1);
    endtask

    logic [3:0] last_loaded;
    logic [3:0] exp_rr [5];
    logic [3:0] exp_first, exp_second;
    logic       prev_l;
    logic [3:0] prev_d;
    int         cyc;
    int         pulses;
    int         n;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        tbl[0] = '{4'b0100, 16'h0700, 1'b0, 4'b0100, 1'b0, 3, 4'd7};
        tbl[1] = '{4'b1000, 16'hD000, 1'b0, 4'b1000, 1'b1, 1, 4'd0};
        tbl[2] = '{4'b0001, 16'h9990, 1'b0, 4'b0001, 1'b0, 3, 4'd0};
        tbl[3] = '{4'b0010, 16'h00C0, 1'b0, 4'b0010, 1'b0, 3, 4'd12};
        tbl[4] = '{4'b0100, 16'h0F00, 1'b0, 4'b0100, 1'b1, 1, 4'd0};
        tbl[5] = '{4'b1000, 16'h9000, 1'b1, 4'b1000, 1'b1, 3, 4'd9};
        tbl[6] = '{4'b0001, 16'hFED3, 1'b0, 4'b0001, 1'b0, 3, 4'd3};

`ifdef CTR_SCHED_PRIO_EN
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0001; exp_rr[2] = 4'b0001;
        exp_rr[3] = 4'b0001; exp_rr[4] = 4'b0001;
        exp_first  = 4'b0001;
        exp_second = 4'b0100;
`else
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        exp_first  = 4'b0100;
        exp_second = 4'b0001;
`endif

        req_data = '0;
        do_reset();
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_data_in", {28'd0, data_in}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wrap", {31'd0, wrap_pulse}, 32'd0);

        // Table of single-requester transfers
        last_loaded = 4'd0;
        for (int unsigned v = 0; v < 7; v++) begin
            wait_idle();
            req      = tbl[v].req;
            req_data = tbl[v].rdata;
            corrupt  = tbl[v].corrupt;
            for (int t = 1; t <= tbl[v].lat; t++) begin
                step();
                if (tbl[v].lat == 3 && t == 1) begin
                    chk("vec_load", {31'd0, load}, 32'd1);
                    chk("vec_data_in", {28'd0, data_in}, {28'd0, tbl[v].exp_val});
                end else begin
                    chk("vec_load_low", {31'd0, load}, 32'd0);
                end
                if (t < tbl[v].lat) begin
                    chk("vec_gnt_early", {28'd0, gnt}, 32'd0);
                end else begin
                    chk("vec_gnt", {28'd0, gnt}, {28'd0, tbl[v].exp_gnt});
                    chk("vec_err", {31'd0, err}, {31'd0, tbl[v].exp_err});
                end
            end
            req     = '0;
            corrupt = 1'b0;
            if (tbl[v].lat == 3) last_loaded = tbl[v].exp_val;
            chk("vec_data_in_hold", {28'd0, data_in}, {28'd0, last_loaded});
        end
        wait_idle();

        // Reset held during a LOAD cycle aborts the transfer
        do_reset();
        req      = 4'b0100;
        req_data = 16'h0700;
        step();
        chk("rl_load_before", {31'd0, load}, 32'd1);
        rst = 1'b1;
        step();
        chk("rl_load", {31'd0, load}, 32'd0);
        chk("rl_gnt", {28'd0, gnt}, 32'd0);
        chk("rl_busy", {31'd0, busy}, 32'd0);
        step();
        rst      = 1'b0;
        req      = 4'b0010;
        req_data = 16'h0050;
        step();
        chk("rl_load_next", {31'd0, load}, 32'd1);
        chk("rl_data_in_next", {28'd0, data_in}, 32'd5);
        step();
        step();
        chk("rl_gnt_next", {28'd0, gnt}, 32'b0010);
        chk("rl_err_next", {31'd0, err}, 32'd0);
        req = '0;
        wait_idle();

        // Round-robin with all requesters held
        do_reset();
        req_data = 16'h4321;
        req      = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            wait_gnt(cyc);
            chk("rr_gnt", {28'd0, gnt}, {28'd0, exp_rr[k]});
            chk("rr_err", {31'd0, err}, 32'd0);
            chk("rr_gap", cyc, (k == 0) ? 32'd3 : 32'd4);
        end
        req = '0;
        wait_idle();

        // Pointer at 2, then requesters 0 and 2 together
        do_reset();
        req      = 4'b0010;
        req_data = 16'h0040;
        wait_gnt(cyc);
        chk("pr_setup_gnt", {28'd0, gnt}, 32'b0010);
        req = '0;
        wait_idle();
        req_data = 16'h0602;
        req      = 4'b0101;
        wait_gnt(cyc);
        chk("pr_first", {28'd0, gnt}, {28'd0, exp_first});
        req = req & ~exp_first;
        wait_gnt(cyc);
        chk("pr_second", {28'd0, gnt}, {28'd0, exp_second});
        chk("pr_gap", cyc, 32'd4);
        req = '0;
        wait_idle();

        // Natural wrap with free-running counter
        do_reset();
        pulses = 0;
        for (int unsigned c = 0; c < 40; c++) begin
            prev_d = data_out;
            prev_l = load;
            step();
            chk("wrap_cycle", {31'd0, wrap_pulse},
                {31'd0, (prev_d == 4'd12) && !prev_l});
            if (wrap_pulse) pulses++;
        end
        chk("wrap_count", pulses, 32'd3);

        // Load of 12 coinciding with data_out==12 suppresses the pulse
        n = 0;
        while (data_out !== 4'd11 && n < 20) begin
            step();
            n++;
        end
        chk("sup_sync", {28'd0, data_out}, 32'd11);
        req      = 4'b0001;
        req_data = 16'h000C;
        step();
        chk("sup_load", {31'd0, load}, 32'd1);
        chk("sup_dout_at_load", {28'd0, data_out}, 32'd12);
        step();
        chk("sup_no_wrap", {31'd0, wrap_pulse}, 32'd0);
        step();
        chk("sup_gnt", {28'd0, gnt}, 32'b0001);
        chk("sup_err", {31'd0, err}, 32'd0);
        chk("sup_wrap_after", {31'd0, wrap_pulse}, 32'd1);
        req = '0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctr_load_sched.md
Name: ctr_load_sched

Overview:
- Shares one loadable wrap-at-12 counter between NREQ requesters that each want to preload it.
- Round-robin arbitration; sequences the counter's load strobe and data bus.
- Checks that the counter actually took the value and flags every terminal-count wrap.
- Sits between the requester blocks and the counter instance: drives the counter's load/data_in, observes its data_out.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, counter data width.
- WRAP, 12, counter terminal value; the counter goes WRAP -> 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester load request; held high until its gnt.
- req_data  input  NREQ*DW  load value; requester i occupies bits [i*DW +: DW].
- gnt  output  NREQ  one-hot completion pulse, 1 cycle.
- err  output  1  1-cycle pulse with gnt: request rejected or load mismatch.
- load  output  1  to counter load.
- data_in  output  DW  to counter data_in.
- data_out  input  DW  counter current value.
- busy  output  1  high whenever FSM is not IDLE.
- wrap_pulse  output  1  1-cycle pulse after counter wraps naturally.

Behaviour:
- Reset (sync, rst=1 at posedge) clears all of the following:
  - Outputs to 0.
  - FSM to IDLE.
  - Round-robin pointer to 0.
  - Latched winner and latched data to 0.
- Reset mid-operation aborts the transfer: no gnt, no err.
- All outputs are registered.
- FSM states: IDLE, LOAD, CHECK, DONE.
- IDLE:
  - If any req is high, select the winner.
  - Winner is the first requester at or after the pointer, in increasing index with wrap-around.
  - Latch winner index and its req_data.
  - If the latched value is <= WRAP, go to LOAD.
  - Otherwise go to DONE with err set (reject; the counter is untouched).
- LOAD:
  - load=1 and data_in=latched value for exactly this cycle.
  - Go to CHECK.
- CHECK:
  - Compare data_out to the latched value.
  - Set err if they are not equal.
  - Go to DONE.
- DONE:
  - gnt[winner]=1 for this cycle; err as decided; busy=0 next cycle.
  - Pointer becomes winner+1 mod NREQ.
  - Go to IDLE.
- Latency:
  - Accepted request: req seen in IDLE at cycle 0 -> load in cycle 1 -> check in cycle 2 -> gnt in cycle 3.
  - Rejected request: gnt in cycle 1.
- Back-to-back: next arbitration happens in the IDLE cycle after DONE. Throughput is 1 load per 4 cycles.
- A requester must keep req and req_data stable until its gnt. Data is latched in IDLE, so later changes are ignored.
- A requester dropping req before gnt is still granted; the latched transfer completes.
- data_in holds its last driven value when load=0.
- wrap_pulse:
  - Registered.
  - Asserted the cycle after the controller observes data_out==WRAP while load==0, i.e. in the cycle where the counter shows 0.
  - Suppressed when a load coincides with data_out==WRAP.
- Width rule: comparisons are unsigned DW-bit.

Optional Feature:
- Macro: CTR_SCHED_PRIO_EN.
- Defined: requester 0 has fixed absolute priority. If req[0] is high in IDLE, it wins regardless of the pointer. The pointer still advances normally when any other requester wins, and is not changed when requester 0 wins.
- Undefined: pure round-robin for all requesters as above.

Test Plan:
- Reset clears state: hold rst 2 cycles during a LOAD cycle -> load=0, gnt=0, busy=0 next cycle. A later req[1] with data 5 is served first, since the pointer is 0 and only req[1] is set.
- Single request: req[2]=1, data 7 -> load=1 with data_in=7 exactly one cycle later. data_out=7 in CHECK. gnt=4'b0100 with err=0 three cycles after the request.
- Round-robin fairness: req=4'b1111 held, data i+1 -> grant order 0,1,2,3,0. Each gnt is 4 cycles apart.
- Out-of-range value: req[3], data 13 -> no load; gnt[3] and err in cycle 1. The counter continues counting.
- Natural wrap: no requests, counter free-running -> wrap_pulse once per 13 cycles, in the cycle data_out=0. Load 12 via req[0] -> no wrap_pulse for that load cycle.
- With CTR_SCHED_PRIO_EN defined: pointer=2, req=4'b0101 -> requester 0 granted first, then 2. Without the macro: 2 is granted first, then 0.
